// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator: one register stage per shift level, MSB of the
// shift amount first, valid/ready handshake with full backpressure on both sides.
module barrel_shifter_pipe #(
  parameter int DW = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DW-1:0]         i_a,
  input  logic [$clog2(DW)-1:0] i_k,
  input  logic [1:0]            i_mode,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DW-1:0]         o_y
);

  localparam int KW = $clog2(DW);

  // Stage registers. Only data and valid are needed after the last level, so the
  // control fields exist for stages 0..KW-2.
  logic [DW-1:0] data_q [KW];
  logic [KW-1:0] k_q    [KW-1];
  logic [1:0]    mode_q [KW-1];
  logic [KW-2:0] sign_q;
  logic [KW-1:0] vld_q;

  logic [KW-1:0] stage_ready;
  logic [DW-1:0] src_data [KW];
  logic [DW-1:0] nxt_data [KW];
  logic [KW-1:0] src_k    [KW];
  logic [1:0]    src_mode [KW];
  logic [KW-1:0] src_sign;
  logic [KW-1:0] src_vld;

  function automatic logic [DW-1:0] shift_step(input logic [DW-1:0] d, input int sh,
                                               input logic [1:0] m, input logic sgn);
    logic [DW-1:0] fill;
    fill = sgn ? ~({DW{1'b1}} >> sh) : '0;
    case (m)
      2'b00:   return (d >> sh) | (d << (DW - sh));
      2'b01:   return (d << sh) | (d >> (DW - sh));
      2'b10:   return d >> sh;
      default: return (d >> sh) | fill;
    endcase
  endfunction

  always_comb begin
    logic r;
    r = 1'b0;
    // A stage can take a beat if it, or any stage below it, is empty, or the consumer drains.
    for (int s = 0; s < KW; s++) begin
      r = i_ready;
      for (int j = s; j < KW; j++) r = r | ~vld_q[j];
      stage_ready[s] = r;
    end

    src_data[0] = i_a;
    src_k[0]    = i_k;
    src_mode[0] = i_mode;
    src_sign[0] = i_a[DW-1];
    src_vld[0]  = i_valid;
    for (int s = 1; s < KW; s++) begin
      src_data[s] = data_q[s-1];
      src_k[s]    = k_q[s-1];
      src_mode[s] = mode_q[s-1];
      src_sign[s] = sign_q[s-1];
      src_vld[s]  = vld_q[s-1];
    end

    // The amount is realigned every stage so the bit for this level is always the MSB.
    for (int s = 0; s < KW; s++) begin
      nxt_data[s] = src_k[s][KW-1] ?
                    shift_step(src_data[s], 1 << (KW - 1 - s), src_mode[s], src_sign[s]) :
                    src_data[s];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      vld_q  <= '0;
      sign_q <= '0;
      for (int s = 0; s < KW; s++) data_q[s] <= '0;
      for (int s = 0; s < KW - 1; s++) begin
        k_q[s]    <= '0;
        mode_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < KW; s++) begin
        if (stage_ready[s]) begin
          vld_q[s]  <= src_vld[s];
          data_q[s] <= nxt_data[s];
        end
      end
      for (int s = 0; s < KW - 1; s++) begin
        if (stage_ready[s]) begin
          k_q[s]    <= src_k[s] << 1;
          mode_q[s] <= src_mode[s];
          sign_q[s] <= src_sign[s];
        end
      end
    end
  end

  assign o_ready = stage_ready[0] & i_rstn;
  assign o_valid = vld_q[KW-1];
  assign o_y     = data_q[KW-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at DW=8 and DW=16 with directed vectors.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        v0, ordy0, ov0, ir0;
  logic [7:0]  a0, y0;
  logic [2:0]  k0;
  logic [1:0]  m0;
  logic        v1, ordy1, ov1, ir1;
  logic [15:0] a1, y1;
  logic [3:0]  k1;
  logic [1:0]  m1;

  barrel_shifter_pipe #(.DW(8)) dut8 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(v0), .o_ready(ordy0), .i_a(a0), .i_k(k0),
    .i_mode(m0), .o_valid(ov0), .i_ready(ir0), .o_y(y0));

  barrel_shifter_pipe #(.DW(16)) dut16 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(v1), .o_ready(ordy1), .i_a(a1), .i_k(k1),
    .i_mode(m1), .o_valid(ov1), .i_ready(ir1), .o_y(y1));

  typedef struct {
    logic [15:0] data;
    int          acc;
    bit          chk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  bit   seen [2];
  int   first [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send(input int inst, input logic [15:0] a, input int k, input logic [1:0] m,
                      input logic [15:0] exp, input bit chk, output bit waited);
    bit   accepted;
    exp_t e;
    accepted = 0;
    waited = 0;
    if (inst == 0) begin a0 = a[7:0]; k0 = k[2:0]; m0 = m; v0 = 1'b1; end
    else           begin a1 = a;      k1 = k[3:0]; m1 = m; v1 = 1'b1; end
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if ((inst == 0) ? ordy0 : ordy1) begin
        e.data = exp; e.acc = cyc; e.chk = chk;
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
        accepted = 1;
        break;
      end
      waited = 1;
      @(posedge clk); #1;
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (inst == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic mon(input int inst);
    logic        ov, ir;
    logic [15:0] y;
    int          kw;
    exp_t        e;
    ov = (inst == 0) ? ov0 : ov1;
    ir = (inst == 0) ? ir0 : ir1;
    y  = (inst == 0) ? {8'h00, y0} : y1;
    kw = (inst == 0) ? 3 : 4;
    if (!rstn) begin
      seen[inst] = 0;
    end else if (ov) begin
      if (!seen[inst]) begin seen[inst] = 1; first[inst] = cyc; end
      if (ir) begin
        if ((inst == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          check("unexpected_beat", {16'h0, y}, 32'hFFFF_FFFF);
        end else begin
          e = (inst == 0) ? q0.pop_front() : q1.pop_front();
          check((inst == 0) ? "y_dw8" : "y_dw16", {16'h0, y}, {16'h0, e.data});
          if (e.chk) check("latency", first[inst] - e.acc, kw);
        end
        seen[inst] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  typedef struct {
    logic [7:0] a;
    int         k;
    logic [1:0] m;
    logic [7:0] y;
  } vec_t;

  vec_t vecs[$] = '{
    '{8'h96, 3, 2'b00, 8'hD2}, '{8'h96, 3, 2'b01, 8'hB4},
    '{8'h96, 3, 2'b10, 8'h12}, '{8'h96, 3, 2'b11, 8'hF2},
    '{8'h96, 0, 2'b00, 8'h96}, '{8'h96, 0, 2'b01, 8'h96},
    '{8'h96, 0, 2'b10, 8'h96}, '{8'h96, 0, 2'b11, 8'h96},
    '{8'h96, 7, 2'b00, 8'h2D}, '{8'h80, 7, 2'b11, 8'hFF},
    '{8'h96, 7, 2'b10, 8'h01}, '{8'h96, 7, 2'b01, 8'h4B}
  };

  initial begin
    bit w;
    rstn = 1'b0;
    v0 = 0; a0 = '0; k0 = '0; m0 = '0; ir0 = 1'b1;
    v1 = 0; a1 = '0; k1 = '0; m1 = '0; ir1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ovalid8", ov0, 0);
    check("rst_y8", y0, 0);
    check("rst_ordy8", ordy0, 0);
    check("rst_y16", y1, 0);
    check("rst_ordy16", ordy1, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("rel_ordy8", ordy0, 1);
    check("rel_ordy16", ordy1, 1);
    @(posedge clk); #1;

    // modes and edge amounts, one beat at a time
    foreach (vecs[i]) begin
      send(0, {8'h00, vecs[i].a}, vecs[i].k, vecs[i].m, {8'h00, vecs[i].y}, 1, w);
      repeat (4) @(posedge clk);
      #1;
    end

    // back-to-back
    send(0, 16'h01, 1, 2'b01, 16'h02, 1, w); check("b2b_ready0", w, 0);
    send(0, 16'h02, 1, 2'b01, 16'h04, 1, w); check("b2b_ready1", w, 0);
    send(0, 16'h04, 1, 2'b01, 16'h08, 1, w); check("b2b_ready2", w, 0);
    repeat (6) @(posedge clk);
    #1;

    // backpressure
    ir0 = 1'b0;
    fork
      begin
        send(0, 16'h01, 1, 2'b01, 16'h02, 0, w);
        send(0, 16'h02, 1, 2'b01, 16'h04, 0, w);
        send(0, 16'h04, 1, 2'b01, 16'h08, 0, w);
        send(0, 16'h08, 1, 2'b01, 16'h10, 0, w);
      end
      begin
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          check("bp_ordy", ordy0, 0);
          check("bp_ovalid", ov0, 1);
          check("bp_y_hold", y0, 8'h02);
          @(negedge clk);
        end
        @(posedge clk); #1 ir0 = 1'b1;
        @(negedge clk);
        check("bp_accept_on_drain", {ordy0, ov0}, 2'b11);
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // reset mid-flight
    send(0, 16'h55, 0, 2'b00, 16'h55, 1, w);
    send(0, 16'hAA, 0, 2'b00, 16'hAA, 1, w);
    rstn = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    check("midrst_ordy", ordy0, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("midrst_ovalid", ov0, 0);
    check("midrst_y", y0, 0);
    check("midrst_ordy_rel", ordy0, 1);
    repeat (6) @(posedge clk);
    #1;

    // width generality
    send(1, 16'h8001, 15, 2'b11, 16'hFFFF, 1, w);
    send(1, 16'h8001, 1, 2'b01, 16'h0003, 1, w);
    send(1, 16'h8001, 0, 2'b10, 16'h8001, 1, w);

    for (int t = 0; t < 100 && (q0.size() != 0 || q1.size() != 0); t++) @(negedge clk);
    check("drain_dw8", q0.size(), 0);
    check("drain_dw16", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
